// File: rtl/mips_pipe_pkg.sv
// Shared types for the MIPS pipeline registers: the EX/MEM payload layout
// and the state encoding used by every skid-buffered stage.
package mips_pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    // EX/MEM payload at the default datapath widths. Stages built with other
    // widths keep exactly this field order.
    typedef struct packed {
        logic [DATA_W_DEF-1:0] pc_next;
        logic                  memto_reg;
        logic                  reg_write;
        logic [ADDR_W_DEF-1:0] write_addr;
        logic [DATA_W_DEF-1:0] alu_result;
    } ex2mem_t;

    // Number of held entries is encoded directly by the state value.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

    function automatic logic [1:0] state_occupancy(input skid_state_t s);
        logic [1:0] occ;
        occ = 2'd0;
        case (s)
            ONE:     occ = 2'd1;
            TWO:     occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/skid_buf.sv
// Generic valid/ready stage with a head (main) register and an optional
// skid register, so in_ready can come straight from a flop.
module skid_buf
    import mips_pipe_pkg::*;
#(
    parameter int W    = 8,
    parameter bit SKID = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   occupancy
);

    skid_state_t  state_reg, state_next;
    logic [W-1:0] main_reg, main_next;
    logic [W-1:0] skid_reg, skid_next;
    logic         accept, consume;

    // Ready is flop-decoded with a skid entry, otherwise pass-through of out_ready.
    generate
        if (SKID) begin : g_skid
            assign in_ready = (state_reg != TWO);
        end else begin : g_single
            assign in_ready = (state_reg == EMPTY) | out_ready;
        end
    endgenerate

    assign accept    = in_valid & in_ready;
    assign out_valid = (state_reg != EMPTY);
    assign consume   = out_valid & out_ready;
    assign out_data  = main_reg;
    assign occupancy = state_occupancy(state_reg);

    // Next-state and register-load decisions; flush overrides everything.
    always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;
        case (state_reg)
            EMPTY: begin
                if (accept) begin
                    state_next = ONE;
                    main_next  = in_data;
                end
            end
            ONE: begin
                if (accept && consume) begin
                    main_next = in_data;
                end else if (accept) begin
                    // Only reachable with SKID=1: single-entry ready implies consume.
                    state_next = TWO;
                    skid_next  = in_data;
                end else if (consume) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                if (consume) begin
                    state_next = ONE;
                    main_next  = skid_reg;
                end
            end
            default: state_next = EMPTY;
        endcase
        if (flush) begin
            state_next = EMPTY;
        end
    end

    // State and storage registers, cleared asynchronously on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= EMPTY;
            main_reg  <= '0;
            skid_reg  <= '0;
        end else begin
            state_reg <= state_next;
            main_reg  <= main_next;
            skid_reg  <= skid_next;
        end
    end

endmodule

// File: rtl/pipe_reg_ex2mem_skid.sv
// EX->MEM pipeline register: skid-buffered valid/ready stage carrying the
// EX/MEM payload, with bubble gating and optional $zero write suppression.
module pipe_reg_ex2mem_skid
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int SKID         = 1,
    parameter int ZERO_WR_KILL = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] PC_next_EX,
    input  logic              MemtoReg_EX,
    input  logic              RegWrite_EX,
    input  logic [ADDR_W-1:0] writeAddr_EX,
    input  logic [DATA_W-1:0] ALU_result_EX,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] PC_next_MEM,
    output logic              MemtoReg_MEM,
    output logic              RegWrite_MEM,
    output logic [ADDR_W-1:0] writeAddr_MEM,
    output logic [DATA_W-1:0] ALU_result_MEM,
    output logic [1:0]        occupancy
);

    // Same field order as ex2mem_t, sized by this instance's parameters.
    typedef struct packed {
        logic [DATA_W-1:0] pc_next;
        logic              memto_reg;
        logic              reg_write;
        logic [ADDR_W-1:0] write_addr;
        logic [DATA_W-1:0] alu_result;
    } payload_t;

    payload_t in_pl, head_pl;
    logic     zero_dst;

    assign in_pl.pc_next    = PC_next_EX;
    assign in_pl.memto_reg  = MemtoReg_EX;
    assign in_pl.reg_write  = RegWrite_EX;
    assign in_pl.write_addr = writeAddr_EX;
    assign in_pl.alu_result = ALU_result_EX;

    skid_buf #(
        .W    ($bits(payload_t)),
        .SKID (SKID != 0)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_pl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head_pl),
        .occupancy (occupancy)
    );

    generate
        if (ZERO_WR_KILL != 0) begin : g_zero_kill
            assign zero_dst = (head_pl.write_addr == '0);
        end else begin : g_no_kill
            assign zero_dst = 1'b0;
        end
    endgenerate

    // Write-enable controls read 0 for bubbles so MEM/WB never act on stale data.
    assign PC_next_MEM    = head_pl.pc_next;
    assign writeAddr_MEM  = head_pl.write_addr;
    assign ALU_result_MEM = head_pl.alu_result;
    assign MemtoReg_MEM   = out_valid & head_pl.memto_reg;
    assign RegWrite_MEM   = out_valid & head_pl.reg_write & ~zero_dst;

endmodule

// File: tb/tb_pipe_reg_ex2mem_skid.sv
// Bench for pipe_reg_ex2mem_skid: directed vector table on the SKID=1
// instance, an asynchronous-reset sequence, then random traffic on both a
// SKID=1 and a SKID=0 instance checked against per-instance FIFO models.
module tb_pipe_reg_ex2mem_skid;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] pc_ex, alu_ex;
    logic        m_ex, rw_ex;
    logic [4:0]  wa_ex;

    // SKID=1 instance
    logic        iv1, ir1, ov1, or1, m1, rw1;
    logic [31:0] pc1, alu1;
    logic [4:0]  wa1;
    logic [1:0]  occ1;
    // SKID=0 instance
    logic        iv0, ir0, ov0, or0, m0, rw0;
    logic [31:0] pc0, alu0;
    logic [4:0]  wa0;
    logic [1:0]  occ0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipe_reg_ex2mem_skid #(.DATA_W(32), .ADDR_W(5), .SKID(1), .ZERO_WR_KILL(1)) dut_skid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(iv1), .in_ready(ir1),
        .PC_next_EX(pc_ex), .MemtoReg_EX(m_ex), .RegWrite_EX(rw_ex),
        .writeAddr_EX(wa_ex), .ALU_result_EX(alu_ex),
        .out_valid(ov1), .out_ready(or1),
        .PC_next_MEM(pc1), .MemtoReg_MEM(m1), .RegWrite_MEM(rw1),
        .writeAddr_MEM(wa1), .ALU_result_MEM(alu1), .occupancy(occ1)
    );

    pipe_reg_ex2mem_skid #(.DATA_W(32), .ADDR_W(5), .SKID(0), .ZERO_WR_KILL(1)) dut_single (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(iv0), .in_ready(ir0),
        .PC_next_EX(pc_ex), .MemtoReg_EX(m_ex), .RegWrite_EX(rw_ex),
        .writeAddr_EX(wa_ex), .ALU_result_EX(alu_ex),
        .out_valid(ov0), .out_ready(or0),
        .PC_next_MEM(pc0), .MemtoReg_MEM(m0), .RegWrite_MEM(rw0),
        .writeAddr_MEM(wa0), .ALU_result_MEM(alu0), .occupancy(occ0)
    );

    typedef struct {
        logic [31:0] pc;
        logic        m;
        logic        rw;
        logic [4:0]  wa;
        logic [31:0] alu;
    } ent_t;

    typedef struct {
        logic        iv;
        logic        ordy;
        logic        fl;
        logic [31:0] pc;
        logic        m;
        logic        rw;
        logic [4:0]  wa;
        logic [31:0] alu;
        logic        e_ov;
        logic        e_ir;
        logic [1:0]  e_occ;
        logic [31:0] e_pc;
        logic        e_m;
        logic        e_rw;
        logic [31:0] e_alu;
    } vec_t;

    vec_t vt[16];
    ent_t q1[$];
    ent_t q0[$];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic iv, input logic ordy, input logic fl,
                                input logic [31:0] pc, input logic m, input logic rw,
                                input logic [4:0] wa, input logic [31:0] alu,
                                input logic e_ov, input logic e_ir, input logic [1:0] e_occ,
                                input logic [31:0] e_pc, input logic e_m, input logic e_rw,
                                input logic [31:0] e_alu);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.pc = pc; v.m = m; v.rw = rw;
        v.wa = wa; v.alu = alu; v.e_ov = e_ov; v.e_ir = e_ir; v.e_occ = e_occ;
        v.e_pc = e_pc; v.e_m = e_m; v.e_rw = e_rw; v.e_alu = e_alu;
        return v;
    endfunction

    // Expected outputs derived from the ordered list of held entries.
    task automatic check_model(input string tag, input ent_t q[$], input bit skid,
                               input logic ordy, input logic ov, input logic ir,
                               input logic [1:0] occ, input logic [31:0] pc, input logic m,
                               input logic rw, input logic [4:0] wa, input logic [31:0] alu);
        int n;
        logic exp_ir;
        n = q.size();
        exp_ir = skid ? (n < 2) : ((n == 0) || ordy);
        cmp({tag, " out_valid"}, {31'd0, ov}, {31'd0, n > 0});
        cmp({tag, " in_ready"}, {31'd0, ir}, {31'd0, exp_ir});
        cmp({tag, " occupancy"}, {30'd0, occ}, n);
        if (n > 0) begin
            cmp({tag, " PC_next"}, pc, q[0].pc);
            cmp({tag, " writeAddr"}, {27'd0, wa}, {27'd0, q[0].wa});
            cmp({tag, " ALU_result"}, alu, q[0].alu);
            cmp({tag, " MemtoReg"}, {31'd0, m}, {31'd0, q[0].m});
            cmp({tag, " RegWrite"}, {31'd0, rw}, {31'd0, q[0].rw && (q[0].wa != 5'd0)});
        end else begin
            cmp({tag, " MemtoReg bubble"}, {31'd0, m}, 32'd0);
            cmp({tag, " RegWrite bubble"}, {31'd0, rw}, 32'd0);
        end
    endtask

    initial begin
        // Directed table: inputs held for one edge, expectations after it.
        vt[0]  = mk(1,1,0, 32'h00400000,1,1,5'd3,32'hABC12345, 1,1,2'd1, 32'h00400000,1,1,32'hABC12345);
        vt[1]  = mk(1,1,0, 32'h00400004,0,1,5'd4,32'hABC12346, 1,1,2'd1, 32'h00400004,0,1,32'hABC12346);
        vt[2]  = mk(1,1,0, 32'h00400008,0,0,5'd5,32'hABC12347, 1,1,2'd1, 32'h00400008,0,0,32'hABC12347);
        vt[3]  = mk(1,1,0, 32'h0040000C,0,1,5'd6,32'hABC12348, 1,1,2'd1, 32'h0040000C,0,1,32'hABC12348);
        vt[4]  = mk(1,0,0, 32'h00400010,0,1,5'd7,32'hABC12349, 1,0,2'd2, 32'h0040000C,0,1,32'hABC12348);
        vt[5]  = mk(1,0,0, 32'h00400014,0,1,5'd8,32'h11111111, 1,0,2'd2, 32'h0040000C,0,1,32'hABC12348);
        vt[6]  = mk(1,0,0, 32'h00400018,0,1,5'd9,32'h22222222, 1,0,2'd2, 32'h0040000C,0,1,32'hABC12348);
        vt[7]  = mk(0,1,0, 32'h0,0,0,5'd0,32'h0,               1,1,2'd1, 32'h00400010,0,1,32'hABC12349);
        vt[8]  = mk(0,1,0, 32'h0,0,0,5'd0,32'h0,               0,1,2'd0, 32'h0,0,0,32'h0);
        vt[9]  = mk(1,0,0, 32'h00400020,1,1,5'd5,32'h33333333, 1,1,2'd1, 32'h00400020,1,1,32'h33333333);
        vt[10] = mk(1,0,0, 32'h00400024,0,1,5'd6,32'h44444444, 1,0,2'd2, 32'h00400020,1,1,32'h33333333);
        vt[11] = mk(1,0,1, 32'h00400028,0,1,5'd7,32'h55555555, 0,1,2'd0, 32'h0,0,0,32'h0);
        vt[12] = mk(1,1,1, 32'h0040002C,1,1,5'd8,32'h66666666, 0,1,2'd0, 32'h0,0,0,32'h0);
        vt[13] = mk(1,0,0, 32'h00400030,0,1,5'd0,32'h77777777, 1,1,2'd1, 32'h00400030,0,0,32'h77777777);
        vt[14] = mk(1,1,0, 32'h00400034,0,1,5'd1,32'h88888888, 1,1,2'd1, 32'h00400034,0,1,32'h88888888);
        vt[15] = mk(0,1,0, 32'h0,0,0,5'd0,32'h0,               0,1,2'd0, 32'h0,0,0,32'h0);

        rst = 1'b1; flush = 1'b0;
        iv1 = 0; or1 = 0; iv0 = 0; or0 = 0;
        pc_ex = '0; alu_ex = '0; m_ex = 0; rw_ex = 0; wa_ex = '0;
        repeat (2) @(negedge clk);
        cmp("reset out_valid", {31'd0, ov1}, 32'd0);
        cmp("reset occupancy", {30'd0, occ1}, 32'd0);
        cmp("reset PC_next_MEM", pc1, 32'd0);
        cmp("reset ALU_result_MEM", alu1, 32'd0);
        cmp("reset RegWrite_MEM", {31'd0, rw1}, 32'd0);
        rst = 1'b0;
        #1;
        cmp("reset in_ready", {31'd0, ir1}, 32'd1);

        // Directed table on the SKID=1 instance.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            iv1 = vt[i].iv; or1 = vt[i].ordy; flush = vt[i].fl;
            pc_ex = vt[i].pc; m_ex = vt[i].m; rw_ex = vt[i].rw;
            wa_ex = vt[i].wa; alu_ex = vt[i].alu;
            @(posedge clk);
            #1;
            cmp($sformatf("vec%0d out_valid", i), {31'd0, ov1}, {31'd0, vt[i].e_ov});
            cmp($sformatf("vec%0d in_ready", i), {31'd0, ir1}, {31'd0, vt[i].e_ir});
            cmp($sformatf("vec%0d occupancy", i), {30'd0, occ1}, {30'd0, vt[i].e_occ});
            cmp($sformatf("vec%0d MemtoReg", i), {31'd0, m1}, {31'd0, vt[i].e_m});
            cmp($sformatf("vec%0d RegWrite", i), {31'd0, rw1}, {31'd0, vt[i].e_rw});
            if (vt[i].e_ov) begin
                cmp($sformatf("vec%0d PC_next", i), pc1, vt[i].e_pc);
                cmp($sformatf("vec%0d ALU_result", i), alu1, vt[i].e_alu);
            end
            $display("vec %0d: in_valid=%0b out_ready=%0b flush=%0b -> out_valid=%0b occ=%0d pc=%h",
                     i, vt[i].iv, vt[i].ordy, vt[i].fl, ov1, occ1, pc1);
        end

        // Fill to two entries, then assert reset in the middle of a cycle.
        @(negedge clk);
        flush = 0; iv1 = 1; or1 = 0;
        pc_ex = 32'h00400050; m_ex = 1; rw_ex = 1; wa_ex = 5'd2; alu_ex = 32'hCAFEF00D;
        @(negedge clk);
        pc_ex = 32'h00400054;
        @(negedge clk);
        iv1 = 0;
        cmp("pre-reset occupancy", {30'd0, occ1}, 32'd2);
        cmp("pre-reset RegWrite", {31'd0, rw1}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        cmp("async reset out_valid", {31'd0, ov1}, 32'd0);
        cmp("async reset occupancy", {30'd0, occ1}, 32'd0);
        cmp("async reset PC_next", pc1, 32'd0);
        cmp("async reset MemtoReg", {31'd0, m1}, 32'd0);
        cmp("async reset RegWrite", {31'd0, rw1}, 32'd0);
        $display("async reset with two entries held: occ=%0d out_valid=%0b", occ1, ov1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        cmp("post-reset in_ready", {31'd0, ir1}, 32'd1);

        // Random traffic on both instances against ordered-list models.
        for (int c = 0; c < 300; c++) begin
            logic ir_lo, ir_hi, acc1, acc0, cons1, cons0;
            @(negedge clk);
            iv1 = ($urandom_range(0, 3) != 0);
            or1 = ($urandom_range(0, 2) != 0);
            iv0 = ($urandom_range(0, 3) != 0);
            or0 = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 39) == 0);
            pc_ex = $urandom; alu_ex = $urandom;
            m_ex = $urandom_range(0, 1); rw_ex = $urandom_range(0, 1);
            wa_ex = 5'($urandom_range(0, 3));
            #1;
            check_model("skid1", q1, 1'b1, or1, ov1, ir1, occ1, pc1, m1, rw1, wa1, alu1);
            check_model("skid0", q0, 1'b0, or0, ov0, ir0, occ0, pc0, m0, rw0, wa0, alu0);
            // With a skid entry, in_ready must not react to out_ready in-cycle.
            or1 = 1'b0; #1; ir_lo = ir1;
            or1 = 1'b1; #1; ir_hi = ir1;
            cmp("skid1 in_ready vs out_ready", {31'd0, ir_hi}, {31'd0, ir_lo});
            or1 = ($urandom_range(0, 2) != 0);
            #1;
            acc1  = iv1 && (q1.size() < 2);
            cons1 = or1 && (q1.size() > 0);
            acc0  = iv0 && ((q0.size() == 0) || or0);
            cons0 = or0 && (q0.size() > 0);
            $display("cyc %0d: skid1 acc=%0b cons=%0b n=%0d | skid0 acc=%0b cons=%0b n=%0d | flush=%0b",
                     c, acc1, cons1, q1.size(), acc0, cons0, q0.size(), flush);
            @(posedge clk);
            if (cons1) void'(q1.pop_front());
            if (cons0) void'(q0.pop_front());
            if (flush) begin
                q1.delete();
                q0.delete();
            end else begin
                if (acc1) q1.push_back('{pc_ex, m_ex, rw_ex, wa_ex, alu_ex});
                if (acc0) q0.push_back('{pc_ex, m_ex, rw_ex, wa_ex, alu_ex});
            end
        end
        @(negedge clk);
        #1;
        check_model("final skid1", q1, 1'b1, or1, ov1, ir1, occ1, pc1, m1, rw1, wa1, alu1);
        check_model("final skid0", q0, 1'b0, or0, ov0, ir0, occ0, pc0, m0, rw0, wa0, alu0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_reg_ex2mem_skid.md
# pipe_reg_ex2mem_skid

Parametrised EX→MEM pipeline register with valid/ready flow control, a two-entry skid buffer, synchronous flush and bubble gating of write-enable controls. It replaces the free-running EX/MEM latch. MEM back-pressure (e.g. a multi-cycle data-memory access) can stall EX without a combinational ready path, and EX can flush wrong-path instructions. Payload fields match the existing EX/MEM stage: PC_next, MemtoReg, RegWrite, writeAddr, ALU_result.

## Interface
- DATA_W, 32, width of PC_next and ALU_result
- ADDR_W, 5, width of register-file write address
- SKID, 1, 1 = two-entry skid (registered in_ready); 0 = single entry (in_ready = !out_valid | out_ready)
- ZERO_WR_KILL, 1, 1 = force RegWrite_MEM low when writeAddr_MEM == 0

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous kill of all held and incoming entries
- in_valid  in  1  EX presents a valid instruction
- in_ready  out  1  stage can accept this cycle
- PC_next_EX  in  DATA_W  payload
- MemtoReg_EX  in  1  payload
- RegWrite_EX  in  1  payload
- writeAddr_EX  in  ADDR_W  payload
- ALU_result_EX  in  DATA_W  payload
- out_valid  out  1  MEM-side entry valid
- out_ready  in  1  MEM consumes this cycle
- PC_next_MEM  out  DATA_W  payload of head entry
- MemtoReg_MEM  out  1  head control, gated by out_valid
- RegWrite_MEM  out  1  head control, gated by out_valid (and ZERO_WR_KILL)
- writeAddr_MEM  out  ADDR_W  payload of head entry
- ALU_result_MEM  out  DATA_W  payload of head entry
- occupancy  out  2  entries held (0..2), for debug and verification

## Operation
- Accept = in_valid & in_ready. Consume = out_valid & out_ready.
- Storage: main register (head, drives *_MEM) and skid register (used only when SKID=1).
- States (SKID=1): EMPTY, ONE, TWO. in_ready = (state != TWO), decoded from the state flop only.
  - EMPTY: accept → ONE, main ← input.
  - ONE: accept & consume → ONE, main ← input. Accept & !consume → TWO, skid ← input. Consume only → EMPTY. Otherwise hold.
  - TWO: consume → ONE, main ← skid. Otherwise hold. No accept, since in_ready = 0.
- SKID=0: state is EMPTY/ONE only. in_ready combinational as listed in Interface.
- out_valid = (state != EMPTY).
- Bubble gating: when out_valid = 0, MemtoReg_MEM and RegWrite_MEM read 0. Data fields hold their last value and are don't-care.
- ZERO_WR_KILL=1: RegWrite_MEM = 0 whenever writeAddr_MEM == 0, so a write to $zero never reaches WB.
- flush (highest priority): next state EMPTY; a beat accepted in the same cycle is discarded; a consume in the same cycle still counts on the MEM side.
- Payload and order are preserved exactly: no reordering, no duplication, no loss except on flush.

## Timing
- Reset (async assert, sync release by the surrounding design): state EMPTY, all *_MEM outputs 0, out_valid 0, occupancy 0, in_ready 1.
- Latency: accepted at edge N → visible on *_MEM with out_valid = 1 after edge N.
- Throughput: 1 beat/cycle while out_ready = 1.
- Stall: out_ready low with ONE held → one more beat accepted into skid; in_ready falls after that edge.
- Release from TWO: in_ready rises one cycle after the first consume, so one bubble-free drain cycle follows.
- Reset mid-operation drops all entries immediately and asynchronously.

## Structure
- Shared package mips_pipe_pkg:
  - typedef ex2mem_t packing PC_next, MemtoReg, RegWrite, writeAddr, ALU_result;
  - state enum shared by all skid stages: EMPTY/ONE/TWO.
- Sub-module skid_buf (generic W, SKID) holds the state machine and the two registers. This block instantiates it on ex2mem_t and adds bubble/zero-write gating, so the IF/ID, ID/EX and MEM/WB successors reuse skid_buf.

## Test plan
- Reset: assert rst mid-cycle with TWO held → outputs immediately 0, occupancy 0, in_ready 1 after release.
- Streaming: out_ready = 1, send PC_next 0x00400000..0x0040000C with ALU_result 0xABC12345 etc. → each appears one cycle later in order, occupancy 1, in_ready stays 1.
- Stall: hold out_ready = 0 for 3 cycles while in_valid = 1 → occupancy 1→2, in_ready 0. Release → beats emerge in order, none lost or duplicated.
- Flush: occupancy 2 plus simultaneous accept with flush = 1 → next cycle out_valid 0, RegWrite_MEM 0, occupancy 0.
- Zero write: RegWrite_EX = 1, writeAddr_EX = 0 → RegWrite_MEM 0. writeAddr_EX = 1 → RegWrite_MEM 1.
- Random valid/ready with SKID = 0 and SKID = 1 against a scoreboard queue → identical ordered output stream, and in_ready has no combinational dependence on out_ready when SKID = 1.
